fifo_uart_tx: RTL and testbench

Serial drain stage that sits directly downstream of the 8-bit FIFO. It pops one byte at a time whenever the FIFO is non-empty and transmission is enabled, then shifts the byte out as an 8N1 UART frame. Its read strobe drives the FIFO's read_Enable. It samples the FIFO's buffer_Output and sig_Empty.

---
 rtl/fifo_uart_tx.sv | 142 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for an 8-bit FIFO. When transmission is enabled and the FIFO
//   reports data, it pops one byte, then shifts it out as an 8N1 UART frame
//   (start bit, 8 data bits LSB first, stop bit).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   DATA_WIDTH    bits per frame (matches the FIFO width, normally 8)
//
// Ports
//   clock          system clock, rising edge
//   reset          synchronous, active-high reset
//   tx_Enable      allows a new frame to start; a running frame always finishes
//   sig_Empty      FIFO empty flag, looked at only while idle
//   buffer_Output  FIFO read data, valid the cycle after read_Enable
//   read_Enable    one-cycle FIFO pop strobe
//   tx_Serial      UART line, idles high
//   tx_Busy        high whenever a pop or frame is in progress
//   tx_Done        one-cycle pulse in the last cycle of the stop bit
//   frames_Sent    completed-frame counter, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_Enable,
  input  logic                  sig_Empty,
  input  logic [DATA_WIDTH-1:0] buffer_Output,
  output logic                  read_Enable,
  output logic                  tx_Serial,
  output logic                  tx_Busy,
  output logic                  tx_Done,
  output logic [15:0]           frames_Sent
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [15:0]           frames_q, frames_d;
  logic                  baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    frames_d  = frames_q;

    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (tx_Enable && !sig_Empty) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        // FIFO data arrives one cycle after the pop strobe, i.e. now.
        shift_d   = buffer_Output;
        bit_idx_d = '0;
        baud_d    = '0;
        state_d   = S_START;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;   // next bit moves into bit 0
          if (bit_idx_q == IDX_LAST) state_d = S_STOP;
          else                       bit_idx_d = bit_idx_q + IDX_W'(1);
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d   = '0;
          frames_d = frames_q + 16'd1;
          state_d  = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      frames_q  <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      frames_q  <= frames_d;
    end
  end

  // All outputs decode registered state only; no input reaches an output
  // combinationally.
  assign read_Enable = (state_q == S_FETCH);
  assign tx_Busy     = (state_q != S_IDLE);
  assign tx_Done     = (state_q == S_STOP) && baud_last;
  assign tx_Serial   = (state_q == S_START) ? 1'b0 :
                       (state_q == S_DATA)  ? shift_q[0] : 1'b1;
  assign frames_Sent = frames_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Self-checking bench for fifo_uart_tx with CLKS_PER_BIT=4. A queue acts as
//   the upstream FIFO (one-cycle read latency). A transaction-level reference
//   model (cycle offset inside a pop+frame transaction) predicts every output
//   on every cycle; table-driven frames and hand-written sequences add
//   targeted checks for latency, gaps, enable gating and mid-frame reset.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clock;
  logic        reset;
  logic        tx_Enable;
  logic        sig_Empty;
  logic [7:0]  buffer_Output;
  logic        read_Enable;
  logic        tx_Serial;
  logic        tx_Busy;
  logic        tx_Done;
  logic [15:0] frames_Sent;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .tx_Enable    (tx_Enable),
    .sig_Empty    (sig_Empty),
    .buffer_Output(buffer_Output),
    .read_Enable  (read_Enable),
    .tx_Serial    (tx_Serial),
    .tx_Busy      (tx_Busy),
    .tx_Done      (tx_Done),
    .frames_Sent  (frames_Sent)
  );

  // One frame per record: byte pushed and the expected line value per bit
  // slot (bit 0 = start slot, bit 9 = stop slot).
  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[4];

  logic [7:0]  fifo_q[$];

  // Reference model: m_t is the cycle offset inside a transaction
  // (0 = pop strobe, 1 = load, 2..FRAME+1 = serial frame).
  bit          m_active;
  int          m_t;
  logic [7:0]  m_byte;
  logic [15:0] m_frames;

  int n_total;
  int n_bad;
  int cyc;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_out();
    logic re, ser, busy, done;
    int   s;
    re = 1'b0; ser = 1'b1; busy = 1'b0; done = 1'b0;
    if (m_active) begin
      busy = 1'b1;
      re   = (m_t == 0);
      done = (m_t == FRAME + 1);
      if (m_t >= 2) begin
        s = (m_t - 2) / CPB;
        if (s == 0)      ser = 1'b0;
        else if (s <= 8) ser = m_byte[s-1];
      end
    end
    return {12'd0, re, ser, busy, done, m_frames};
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    sig_Empty = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs present at the edge,
  // let the FIFO respond to a pop, then compare all outputs with the model.
  task automatic step();
    logic re_was;
    re_was = read_Enable;
    if (reset) begin
      m_active = 1'b0;
      m_frames = 16'd0;
    end else if (m_active) begin
      if (m_t == FRAME + 1) begin
        m_active = 1'b0;
        m_frames = m_frames + 16'd1;
      end else begin
        m_t++;
      end
    end else if (tx_Enable && !sig_Empty) begin
      m_active = 1'b1;
      m_t      = 0;
      m_byte   = fifo_q[0];
    end
    @(posedge clock);
    #1;
    cyc++;
    if (re_was === 1'b1 && fifo_q.size() > 0) buffer_Output = fifo_q.pop_front();
    sig_Empty = (fifo_q.size() == 0);
    check("cycle", {12'd0, read_Enable, tx_Serial, tx_Busy, tx_Done, frames_Sent}, model_out());
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (n < 500 && (tx_Busy !== 1'b0 || m_active || (tx_Enable && fifo_q.size() > 0))) begin
      step();
      n++;
    end
    check("drain_idle", 32'(tx_Busy), 32'd0);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (n < 100 && tx_Serial !== 1'b0) begin
      step();
      n++;
    end
    check("start_seen", 32'(tx_Serial), 32'd0);
  endtask

  // Samples the middle of each data slot of the next frame.
  task automatic capture_frame(output logic [7:0] b);
    wait_start();
    repeat (CPB + CPB / 2) step();
    b[0] = tx_Serial;
    for (int i = 1; i < 8; i++) begin
      repeat (CPB) step();
      b[i] = tx_Serial;
    end
  endtask

  initial begin
    int         exp_frames;
    int         re_cyc[$];
    int         runs[$];
    int         run;
    int         low2;
    logic       prev;
    bit         any_re, any_low, any_busy, saw, saw_done;
    int         n_re;
    logic [7:0] cap;

    vecs[0] = '{data: 8'hA5, line: 10'b1101001010};
    vecs[1] = '{data: 8'h00, line: 10'b1000000000};
    vecs[2] = '{data: 8'hFF, line: 10'b1111111110};
    vecs[3] = '{data: 8'h81, line: 10'b1100000010};

    n_total = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; tx_Enable = 1'b1; sig_Empty = 1'b1; buffer_Output = 8'h00;

    // 1. Reset held with data waiting and transmission enabled.
    push(8'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_serial", 32'(tx_Serial), 32'd1);
      check("rst_read",   32'(read_Enable), 32'd0);
      check("rst_busy",   32'(tx_Busy), 32'd0);
      check("rst_frames", 32'(frames_Sent), 32'd0);
    end
    reset = 1'b0;
    wait_idle();
    reset = 1'b1;
    step();
    check("rst_clear_frames", 32'(frames_Sent), 32'd0);
    reset = 1'b0;
    step();
    exp_frames = 0;

    // 2. Table-driven single frames, each started from an idle, empty FIFO.
    for (int v = 0; v < 4; v++) begin
      push(vecs[v].data);
      step();
      check("fetch_strobe", 32'(read_Enable), 32'd1);
      step();
      check("load_strobe", 32'(read_Enable), 32'd0);
      check("load_line",   32'(tx_Serial), 32'd1);
      step();
      for (int k = 0; k < FRAME; k++) begin
        check("frame_bit",  32'(tx_Serial), 32'(vecs[v].line[k / CPB]));
        check("done_pulse", 32'(tx_Done), (k == FRAME - 1) ? 32'd1 : 32'd0);
        step();
      end
      exp_frames++;
      check("busy_fall",  32'(tx_Busy), 32'd0);
      check("frames_inc", 32'(frames_Sent), 32'(exp_frames));
    end

    // 3. Back-to-back frames 0x00 then 0xFF.
    push(8'h00);
    push(8'hFF);
    run = 0; low2 = 0; prev = tx_Serial;
    for (int i = 0; i < 120; i++) begin
      step();
      if (read_Enable === 1'b1) re_cyc.push_back(cyc);
      if (tx_Serial === 1'b1) begin
        run++;
      end else begin
        if (prev === 1'b1) runs.push_back(run);
        run = 0;
        if (re_cyc.size() == 2) low2++;
      end
      prev = tx_Serial;
    end
    exp_frames += 2;
    check("b2b_pulses", 32'(re_cyc.size()), 32'd2);
    check("b2b_spacing", (re_cyc.size() == 2) ? 32'(re_cyc[1] - re_cyc[0]) : 32'hFFFF_FFFF, 32'd43);
    check("b2b_gap_high", (runs.size() >= 2) ? 32'(runs[1]) : 32'hFFFF_FFFF, 32'(CPB + 3));
    check("b2b_frame2_low", 32'(low2), 32'(CPB));
    check("b2b_frames", 32'(frames_Sent), 32'(exp_frames));

    // 4. Empty FIFO with transmission enabled.
    wait_idle();
    any_re = 0; any_low = 0; any_busy = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (read_Enable !== 1'b0) any_re = 1;
      if (tx_Serial !== 1'b1)   any_low = 1;
      if (tx_Busy !== 1'b0)     any_busy = 1;
    end
    check("empty_no_read", 32'(any_re), 32'd0);
    check("empty_line_high", 32'(any_low), 32'd0);
    check("empty_not_busy", 32'(any_busy), 32'd0);

    // 5. Enable dropped during data bit 3 with another byte queued.
    push(8'h3C);
    push(8'h99);
    wait_start();
    repeat (CPB + 3 * CPB) step();
    tx_Enable = 1'b0;
    n_re = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (read_Enable === 1'b1) n_re++;
    end
    exp_frames++;
    check("disabled_no_read", 32'(n_re), 32'd0);
    check("disabled_frame_done", 32'(frames_Sent), 32'(exp_frames));
    check("disabled_queue_kept", 32'(fifo_q.size()), 32'd1);
    tx_Enable = 1'b1;
    saw = 0;
    repeat (4) begin
      step();
      if (read_Enable === 1'b1) saw = 1;
    end
    check("resume_read", 32'(saw), 32'd1);
    wait_idle();
    exp_frames++;
    check("resume_frames", 32'(frames_Sent), 32'(exp_frames));

    // 6. Reset during data bit 5, then the next queued byte goes out.
    push(8'h5A);
    push(8'hC3);
    wait_start();
    repeat (CPB + 5 * CPB) step();
    check("mid_busy", 32'(tx_Busy), 32'd1);
    reset = 1'b1;
    step();
    check("mid_rst_line", 32'(tx_Serial), 32'd1);
    check("mid_rst_busy", 32'(tx_Busy), 32'd0);
    check("mid_rst_done", 32'(tx_Done), 32'd0);
    check("mid_rst_frames", 32'(frames_Sent), 32'd0);
    saw_done = 0;
    repeat (2) begin
      step();
      if (tx_Done !== 1'b0) saw_done = 1;
    end
    reset = 1'b0;
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    capture_frame(cap);
    check("post_rst_byte", 32'(cap), 32'h0000_00C3);
    wait_idle();
    check("post_rst_frames", 32'(frames_Sent), 32'd1);

    // 7. Random pushes, enable toggles and occasional resets vs the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0 && fifo_q.size() < 6) push(8'($urandom));
      if ($urandom_range(31) == 0) tx_Enable = ~tx_Enable;
      reset = ($urandom_range(399) == 0);
      step();
    end
    reset = 1'b0;
    tx_Enable = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
